// File: rtl/fetch_pc_predict_pkg.sv
// Shared CPU definitions (cpu_def): instruction opcodes and fetch-stage defaults.
// Imported by the fetch predictor and its BTB storage.
package fetch_pc_predict_pkg;

    localparam int          IDX_BITS_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [6:0] B_TYPE      = 7'b1100011;
    localparam logic [6:0] J_TYPE      = 7'b1101111;
    localparam logic [6:0] I_TYPE_JALR = 7'b1100111;

    // 2-bit direction counter: values 2 and 3 predict taken.
    localparam logic [1:0] CTR_INIT  = 2'd1;
    localparam logic [1:0] CTR_ALLOC = 2'd2;
    localparam logic [1:0] CTR_MAX   = 2'd3;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_MAX) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: async lookup port, and an update port that reads
// the addressed entry combinationally and writes it on the clock edge.
module btb_array
    import fetch_pc_predict_pkg::*;
#(
    parameter int IDX_BITS = IDX_BITS_DEF,
    parameter int TAG_W    = 30 - IDX_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [31:0]         rd_target,
    output logic                rd_taken,
    input  logic [IDX_BITS-1:0] upd_idx,
    output logic                upd_valid,
    output logic [TAG_W-1:0]    upd_tag,
    output logic [31:0]         upd_target,
    output logic [1:0]          upd_ctr,
    input  logic                we,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [31:0]         wr_target,
    input  logic [1:0]          wr_ctr
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic              valid_q  [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];

    // Reads see the registered contents, so a same-cycle write is not forwarded.
    assign rd_valid   = valid_q[rd_idx];
    assign rd_tag     = tag_q[rd_idx];
    assign rd_target  = target_q[rd_idx];
    assign rd_taken   = ctr_q[rd_idx][1];

    assign upd_valid  = valid_q[upd_idx];
    assign upd_tag    = tag_q[upd_idx];
    assign upd_target = target_q[upd_idx];
    assign upd_ctr    = ctr_q[upd_idx];

    // Every write installs or refreshes a live entry, so it always sets valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (we) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= wr_ctr;
        end
    end

    // NOTE: tag and target are left unreset; valid=0 masks them, and skipping reset keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[upd_idx]    <= wr_tag;
            target_q[upd_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/fetch_pc_predict.sv
// Fetch PC register with BTB-based next-PC prediction, E-stage mispredict
// detection, redirect and D/E flush generation.
module fetch_pc_predict
    import fetch_pc_predict_pkg::*;
#(
    parameter int          IDX_BITS = IDX_BITS_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallF,
    output logic [31:0] pcF,
    output logic        pred_takenF,
    output logic [31:0] pred_targetF,
    input  logic        validE,
    input  logic [31:0] instrE,
    input  logic [31:0] pcE,
    input  logic        br_selE,
    input  logic [31:0] alu_resultE,
    input  logic        pred_takenE,
    input  logic [31:0] pred_targetE,
    output logic        mispredictE,
    output logic [31:0] redirect_pcE,
    output logic        flushD,
    output logic        flushE
);

    localparam int TAG_W = 30 - IDX_BITS;

    logic [IDX_BITS-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]    tag_f, tag_e;
    logic [31:0]         pc_plus4_f, pc_plus4_e, tgt_e;
    logic                rd_valid, rd_taken, hit_f;
    logic [TAG_W-1:0]    rd_tag;
    logic [31:0]         rd_target;
    logic                upd_valid, hit_e;
    logic [TAG_W-1:0]    upd_tag;
    logic [31:0]         upd_target;
    logic [1:0]          upd_ctr;
    logic                we;
    logic [31:0]         wr_target;
    logic [1:0]          wr_ctr;
    logic [6:0]          opcode_e;
    logic                is_branch_e, is_jump_e, ctl_e;
    logic                unused_bits;

    assign unused_bits = ^{instrE[31:7], alu_resultE[0]};

    assign idx_f      = pcF[IDX_BITS+1:2];
    assign tag_f      = pcF[31:IDX_BITS+2];
    assign idx_e      = pcE[IDX_BITS+1:2];
    assign tag_e      = pcE[31:IDX_BITS+2];
    assign pc_plus4_f = pcF + 32'd4;
    assign pc_plus4_e = pcE + 32'd4;

    btb_array #(
        .IDX_BITS (IDX_BITS),
        .TAG_W    (TAG_W)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (idx_f),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_taken   (rd_taken),
        .upd_idx    (idx_e),
        .upd_valid  (upd_valid),
        .upd_tag    (upd_tag),
        .upd_target (upd_target),
        .upd_ctr    (upd_ctr),
        .we         (we),
        .wr_tag     (tag_e),
        .wr_target  (wr_target),
        .wr_ctr     (wr_ctr)
    );

    assign hit_f        = rd_valid && (rd_tag == tag_f);
    assign pred_takenF  = hit_f & rd_taken;
    assign pred_targetF = hit_f ? rd_target : pc_plus4_f;

    // JALR targets can be odd; bit 0 is dropped to form the real fetch address.
    assign tgt_e       = {alu_resultE[31:1], 1'b0};
    assign opcode_e    = instrE[6:0];
    assign is_branch_e = (opcode_e == B_TYPE);
    assign is_jump_e   = (opcode_e == J_TYPE) || (opcode_e == I_TYPE_JALR);
    assign ctl_e       = validE && (is_branch_e || is_jump_e);
    assign hit_e       = upd_valid && (upd_tag == tag_e);

    assign mispredictE  = validE &&
                          ((br_selE != pred_takenE) || (br_selE && (pred_targetE != tgt_e)));
    assign redirect_pcE = br_selE ? tgt_e : pc_plus4_e;
    assign flushD       = mispredictE;
    assign flushE       = mispredictE;

    // NOTE: every output gets a default before the if-tree, so no path can infer a latch.
    always_comb begin
        we        = 1'b0;
        wr_target = tgt_e;
        wr_ctr    = CTR_ALLOC;
        if (ctl_e) begin
            if (is_jump_e) begin
                we     = 1'b1;
                wr_ctr = CTR_MAX;
            end else if (hit_e) begin
                we = 1'b1;
                if (br_selE) begin
                    wr_ctr = ctr_inc(upd_ctr);
                end else begin
                    wr_ctr    = ctr_dec(upd_ctr);
                    wr_target = upd_target;
                end
            end else if (br_selE) begin
                we     = 1'b1;
                wr_ctr = CTR_ALLOC;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcF <= RESET_PC;
        end else if (mispredictE) begin
            pcF <= redirect_pcE;
        end else if (!stallF) begin
            pcF <= pred_takenF ? pred_targetF : pc_plus4_f;
        end
    end

endmodule

// File: tb/tb_fetch_pc_predict.sv
// Self-checking bench for fetch_pc_predict: directed scenarios followed by
// randomized E-stage traffic, compared against a behavioural predictor model.
module tb_fetch_pc_predict;
    import fetch_pc_predict_pkg::*;

    localparam int N  = 16;
    localparam int IB = 4;

    logic        clk = 1'b0;
    logic        rst_n, stallF, validE, br_selE, pred_takenE;
    logic [31:0] instrE, pcE, alu_resultE, pred_targetE;
    logic [31:0] pcF, pred_targetF, redirect_pcE;
    logic        pred_takenF, mispredictE, flushD, flushE;

    int checks   = 0;
    int failures = 0;

    // Model: each entry remembers the full PC of the instruction that owns it.
    bit          m_valid  [N];
    logic [31:0] m_owner  [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    logic [31:0] m_pc;
    bit          known = 0;

    localparam logic [31:0] NOP_I  = 32'h0000_0013;
    localparam logic [31:0] BEQ_I  = 32'h0000_0063;
    localparam logic [31:0] JAL_I  = 32'h0000_006F;
    localparam logic [31:0] JALR_I = 32'h0000_0067;

    fetch_pc_predict #(.IDX_BITS(IB), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallF       (stallF),
        .pcF          (pcF),
        .pred_takenF  (pred_takenF),
        .pred_targetF (pred_targetF),
        .validE       (validE),
        .instrE       (instrE),
        .pcE          (pcE),
        .br_selE      (br_selE),
        .alu_resultE  (alu_resultE),
        .pred_takenE  (pred_takenE),
        .pred_targetE (pred_targetE),
        .mispredictE  (mispredictE),
        .redirect_pcE (redirect_pcE),
        .flushD       (flushD),
        .flushE       (flushE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[IB+1:2]);
    endfunction

    task automatic lookup(input logic [31:0] pc, output bit taken, output logic [31:0] target);
        int  i;
        bit  hit;
        i      = idx_of(pc);
        hit    = m_valid[i] && (m_owner[i][31:IB+2] == pc[31:IB+2]);
        taken  = hit && (m_ctr[i] >= 2);
        target = hit ? m_target[i] : pc + 32'd4;
    endtask

    task automatic set_idle();
        validE = 0; instrE = NOP_I; pcE = 0; br_selE = 0;
        alu_resultE = 0; pred_takenE = 0; pred_targetE = 0;
    endtask

    task automatic set_e(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit br, input logic [31:0] alu, input bit pt,
                         input logic [31:0] ptgt);
        validE = v; instrE = ins; pcE = pc; br_selE = br;
        alu_resultE = alu; pred_takenE = pt; pred_targetE = ptgt;
    endtask

    // One cycle: check combinational outputs mid-low-phase, then advance the model on the edge.
    task automatic tick();
        bit          exp_pt, misp, hit;
        logic [31:0] exp_ptgt, tgt, redir, nxt;
        logic [6:0]  op;
        int          j;
        #2;
        tgt   = alu_resultE & ~32'h1;
        misp  = validE && ((br_selE != pred_takenE) || (br_selE && (pred_targetE != tgt)));
        redir = br_selE ? tgt : pcE + 32'd4;
        exp_pt = 0; exp_ptgt = 0;
        if (known) begin
            lookup(m_pc, exp_pt, exp_ptgt);
            check("pcF", pcF, m_pc);
            check("pred_takenF", pred_takenF, exp_pt);
            check("pred_targetF", pred_targetF, exp_ptgt);
        end
        check("mispredictE", mispredictE, misp);
        check("redirect_pcE", redirect_pcE, redir);
        check("flushD", flushD, misp);
        check("flushE", flushE, misp);
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
            m_pc  = 32'h0;
            known = 1;
        end else if (known) begin
            if (misp)        nxt = redir;
            else if (stallF) nxt = m_pc;
            else             nxt = exp_pt ? exp_ptgt : m_pc + 32'd4;
            op = instrE[6:0];
            j  = idx_of(pcE);
            hit = m_valid[j] && (m_owner[j][31:IB+2] == pcE[31:IB+2]);
            if (validE && (op == J_TYPE || op == I_TYPE_JALR)) begin
                m_valid[j] = 1; m_owner[j] = pcE; m_target[j] = tgt; m_ctr[j] = 3;
            end else if (validE && op == B_TYPE) begin
                if (hit && br_selE) begin
                    m_ctr[j]    = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
                    m_target[j] = tgt;
                end else if (hit) begin
                    m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
                end else if (br_selE) begin
                    m_valid[j] = 1; m_owner[j] = pcE; m_target[j] = tgt; m_ctr[j] = 2;
                end
            end
            m_pc = nxt;
        end
        @(negedge clk);
    endtask

    // Steer fetch to pc via a stale-prediction mispredict on a non-control instruction.
    task automatic redirect_to(input logic [31:0] pc);
        set_e(1, NOP_I, pc - 32'd4, 0, 0, 1, 32'h0);
        tick();
        set_idle();
    endtask

    logic [31:0] pool [9] = '{32'h10, 32'h20, 32'h40, 32'h50, 32'h80,
                              32'h200, 32'h410, 32'h420, 32'h1010};

    initial begin
        bit          pt;
        logic [31:0] ptgt, ins, pc;
        int          sel;

        rst_n = 0; stallF = 0;
        set_idle();
        @(negedge clk);
        tick();
        tick();
        rst_n = 1;

        // Sequential fetch out of reset
        for (int k = 0; k < 4; k++) begin
            check("seq_pcF", pcF, 32'(4 * k));
            check("seq_pred_takenF", pred_takenF, 1'b0);
            if (k == 0) check("reset_pred_targetF", pred_targetF, 32'h4);
            tick();
        end

        // Cold taken beq
        set_e(1, BEQ_I, 32'h10, 1, 32'h40, 0, 32'h14);
        #1;
        check("cold_misp", mispredictE, 1'b1);
        check("cold_redirect", redirect_pcE, 32'h40);
        check("cold_flushD", flushD, 1'b1);
        check("cold_flushE", flushE, 1'b1);
        tick();
        set_idle();
        check("cold_pcF", pcF, 32'h40);
        redirect_to(32'h10);
        check("alloc_pcF", pcF, 32'h10);
        check("alloc_taken", pred_takenF, 1'b1);
        check("alloc_target", pred_targetF, 32'h40);

        // Same beq resolved not taken
        set_e(1, BEQ_I, 32'h10, 0, 32'h40, 1, 32'h40);
        #1;
        check("nt_misp", mispredictE, 1'b1);
        check("nt_redirect", redirect_pcE, 32'h14);
        tick();
        redirect_to(32'h10);
        check("nt_taken", pred_takenF, 1'b0);

        // Saturate, then one not-taken
        for (int k = 0; k < 4; k++) begin
            set_e(1, BEQ_I, 32'h10, 1, 32'h40, 0, 32'h14);
            tick();
        end
        set_e(1, BEQ_I, 32'h10, 0, 32'h40, 1, 32'h40);
        tick();
        redirect_to(32'h10);
        check("sat_taken", pred_takenF, 1'b1);

        // Stall vs mispredict
        stallF = 1;
        set_e(1, NOP_I, 32'h30, 0, 0, 1, 32'h0);
        tick();
        set_idle();
        check("stall_misp_pcF", pcF, 32'h34);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold_pcF", pcF, 32'h34);
        end
        stallF = 0;

        // JALR with odd target
        set_e(1, JALR_I, 32'h20, 1, 32'h201, 1, 32'h100);
        #1;
        check("jalr_misp", mispredictE, 1'b1);
        check("jalr_redirect", redirect_pcE, 32'h200);
        tick();
        set_idle();
        check("jalr_pcF", pcF, 32'h200);
        redirect_to(32'h20);
        check("jalr_taken", pred_takenF, 1'b1);
        check("jalr_target", pred_targetF, 32'h200);

        // PC wrap
        redirect_to(32'hFFFF_FFFC);
        check("wrap_pre", pcF, 32'hFFFF_FFFC);
        tick();
        check("wrap_post", pcF, 32'h0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            stallF = ($urandom_range(0, 4) == 0);
            pc  = pool[$urandom_range(0, 8)];
            sel = $urandom_range(0, 3);
            ins = {25'($urandom), 7'h0};
            case (sel)
                0: ins[6:0] = B_TYPE;
                1: ins[6:0] = J_TYPE;
                2: ins[6:0] = I_TYPE_JALR;
                default: ins[6:0] = 7'h33;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                lookup(pc, pt, ptgt);
            end else begin
                pt   = 1'($urandom);
                ptgt = pool[$urandom_range(0, 8)];
            end
            set_e(($urandom_range(0, 4) != 0), ins, pc,
                  (sel == 0) ? 1'($urandom) : (sel != 3),
                  pool[$urandom_range(0, 8)] | 32'($urandom_range(0, 1)),
                  pt, ptgt);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_predict.md
Name: fetch_pc_predict

Overview:
- Fetch-stage PC register with a direct-mapped BTB and 2-bit branch history counters.
- Predicts next PC in F; consumes resolved direction (br_selE) and target from E; detects mispredicts; redirects PC; drives D/E flushes.
- Sits downstream of the E-stage branch selector and upstream of instruction memory.

Parameters:
- IDX_BITS, 4, BTB index width (2^IDX_BITS entries, default 16)
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- stallF  in  1  hold PC (hazard unit)
- pcF  out  32  current fetch PC (registered)
- pred_takenF  out  1  F-stage prediction; piped to E by pipeline regs
- pred_targetF  out  32  F-stage predicted target; piped to E
- validE  in  1  E-stage slot holds a real (non-bubble) instruction
- instrE  in  32  E-stage instruction
- pcE  in  32  E-stage PC
- br_selE  in  1  resolved taken/not-taken from branch selector
- alu_resultE  in  32  resolved target (pcE+imm or rs1+imm)
- pred_takenE  in  1  prediction carried with instrE
- pred_targetE  in  32  predicted target carried with instrE
- mispredictE  out  1  prediction wrong (combinational)
- redirect_pcE  out  32  correct next PC (combinational)
- flushD  out  1  kill IF/ID contents (= mispredictE)
- flushE  out  1  kill ID/EX contents (= mispredictE)

Behaviour:
- Per BTB entry: valid, tag = pc[31:IDX_BITS+2], target[31:0], ctr[1:0].
- Lookup (combinational on pcF):
  - idx = pcF[IDX_BITS+1:2].
  - hit = valid & tag match.
  - pred_takenF = hit & ctr[1].
  - pred_targetF = entry target when hit, else pcF+4.
- Target normalisation: tgt = {alu_resultE[31:1],1'b0}.
- Resolution (combinational):
  - ctl = validE & opcode in {B_TYPE, J_TYPE, I_TYPE_JALR}.
  - mispredictE = validE & ((br_selE != pred_takenE) | (br_selE & (pred_targetE != tgt))).
  - redirect_pcE = br_selE ? tgt : pcE+4.
  - A non-control instruction predicted taken (stale entry) mispredicts and redirects to pcE+4.
  - validE=0 forces mispredictE=0 and no BTB update.
- PC register (posedge clk), priority: reset > mispredictE > stallF > pred_takenF.
  - !rst_n → RESET_PC.
  - mispredictE → redirect_pcE (overrides stallF).
  - stallF → hold.
  - otherwise → pred_takenF ? pred_targetF : pcF+4.
  - PC arithmetic is modulo 2^32; 0xFFFF_FFFC+4 wraps to 0.
- BTB update (posedge clk, only when ctl; indexed by pcE). Updates are not gated by stallF.
  - J_TYPE/JALR: set valid, tag, target=tgt, ctr=3.
  - B_TYPE hit, taken: ctr saturating +1 (max 3), target=tgt.
  - B_TYPE hit, not taken: ctr saturating −1 (min 0); target unchanged.
  - B_TYPE miss, taken: allocate (replace victim), ctr=2, target=tgt.
  - B_TYPE miss, not taken: no change.
- Read/write collision on the same index in one cycle: lookup returns pre-update contents.
- Reset:
  - all valid=0, all ctr=1, pcF=RESET_PC.
  - Combinational outputs then follow: pred_takenF=0, pred_targetF=RESET_PC+4.
  - Reset asserted mid-operation discards all BTB state on that edge.

Decomposition:
- Opcode constants B_TYPE, J_TYPE and I_TYPE_JALR come from the shared cpu_def header; no local redefinition.
- Add IDX_BITS default and RESET_PC to the shared header.
- One sub-module, btb_array:
  - storage for valid, tag, target and ctr;
  - one async read port, one sync write port;
  - sync reset of valid and ctr.
- Counter update and mispredict logic stay in the top module.

Test Plan:
- Reset, RESET_PC=0, no E traffic → pcF sequence 0x0, 0x4, 0x8, 0xC; pred_takenF=0 throughout.
- Cold taken beq at pcE=0x10, alu_resultE=0x40, pred_takenE=0 → mispredictE=flushD=flushE=1, redirect_pcE=0x40, pcF=0x40 next cycle. Later pcF=0x10 → pred_takenF=1, pred_targetF=0x40.
- Same beq (ctr=2) resolved not taken with pred_takenE=1 → mispredictE=1, redirect 0x14, ctr=1. Next lookup of 0x10 → pred_takenF=0.
- Four taken resolutions (ctr=3), then one not taken → ctr=2; lookup still pred_takenF=1.
- stallF=1 and mispredictE=1 in the same cycle → pcF loads redirect_pcE. stallF=1 alone for 3 cycles → pcF held.
- JALR at pcE=0x20: pred_takenE=1, pred_targetE=0x100, alu_resultE=0x201 → mispredictE=1, redirect 0x200, entry target becomes 0x200.
